// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory access stage, control unit and MBR.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package mem_pkg;

  // Default geometry; the MBR and RAM must agree on DATA_W.
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;

  // Control-word layout shared with the control unit and the MBR.
  localparam int CTRL_W     = 16;
  localparam int RD_BIT_DEF = 5;   // memory -> MBR read strobe
  localparam int WR_BIT_DEF = 11;  // MBR -> memory write strobe

  // Wait-state counter width; WAIT_CYCLES must fit in it (0..15).
  localparam int CNT_W = 4;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Kind of access latched at accept time.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Write wins when both strobes are raised together, matching the MBR
  // priority on the ACC path.
  function automatic op_t decode_op(input logic rd, input logic wr);
    decode_op = wr ? OP_WRITE : (rd ? OP_READ : OP_READ);
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Word-addressed synchronous single-port RAM, contents not reset.
// Latency: rdata registered, valid the cycle after addr is presented.
// Backpressure: none; one read and optional write every cycle.
module sp_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Read-first port: rdata shows the word stored before any same-edge write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_access_unit.sv
// Sequences one MAR/MBR memory access at a time against a single-port RAM.
// Latency: access at accept edge + WAIT_CYCLES + 1; mem_ready pulses the cycle after.
// Backpressure: none queued; strobes while busy or not re-armed are ignored.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2,
  parameter int RD_BIT      = RD_BIT_DEF,
  parameter int WR_BIT      = WR_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] control_signals,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic [DATA_W-1:0] mbr_data,
  output logic [DATA_W-1:0] mem2mbr,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  // Sequencer state and request latches.
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              armed_q, armed_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  op_t               op_q;

  // Next values of the registered outputs.
  logic              busy_d;
  logic              ready_d;
  logic              err_d;
  logic              latch_req;

  // Strobe decode.
  logic              rd;
  logic              wr;
  logic              accept;
  logic              access;

  // RAM port.
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  // Only the two strobe bits matter here; the rest belong to other stages.
  logic              unused_ctrl;
  assign unused_ctrl = ^control_signals;

  assign rd     = control_signals[RD_BIT];
  assign wr     = control_signals[WR_BIT];
  assign accept = (state_q == IDLE) && armed_q && (rd || wr);
  assign access = (state_q == WAIT) && (cnt_q == '0);

  // While idle the RAM looks at the live MAR so that, with zero wait states,
  // the word is already in the RAM output register at the access edge. Once
  // accepted, the latched address keeps the port immune to MAR changes.
  assign ram_addr = (state_q == IDLE) ? mar_addr : addr_q;

  // A reset edge that coincides with the access edge must not commit a write.
  assign ram_we = access && (op_q == OP_WRITE) && !rst;

  sp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Next-state, arming and output decode for the access sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = mem_busy;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    latch_req = 1'b0;
    // Dropping both strobes re-arms, so a strobe held across completion
    // cannot start a second access.
    armed_d   = armed_q || (!rd && !wr);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          latch_req = 1'b1;
          armed_d   = 1'b0;
          cnt_d     = WAIT_INIT;
          busy_d    = 1'b1;
          err_d     = rd && wr;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latches and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_q      <= OP_READ;
      mem2mbr   <= '0;
      mem_ready <= 1'b0;
      mem_busy  <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      mem_ready <= ready_d;
      mem_busy  <= busy_d;
      mem_err   <= err_d;
      if (latch_req) begin
        addr_q  <= mar_addr;
        wdata_q <= mbr_data;
        op_q    <= decode_op(rd, wr);
      end
      if (access && (op_q == OP_READ)) begin
        mem2mbr <= ram_rdata;
      end
    end
  end

endmodule
